// File: rtl/jk_trio_checker_pkg.sv
// Shared definitions for the JK trio checker: FSM state encoding, lane indices,
// JK opcodes and the golden next-state function.
package jk_trio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WARM  = 2'd1,
    ST_CHECK = 2'd2,
    ST_FAULT = 2'd3
  } chk_state_t;

  localparam int LANE_SR = 0;
  localparam int LANE_D  = 1;
  localparam int LANE_T  = 2;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TOG  = 2'b11;

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic nxt;
    case ({j, k})
      JK_HOLD: nxt = q;
      JK_RST:  nxt = 1'b0;
      JK_SET:  nxt = 1'b1;
      default: nxt = ~q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jk_trio_checker_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module jk_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/jk_trio_checker.sv
// Lockstep checker for the three-lane JK flop unit: golden JK model, per-lane compare,
// saturating counters, sticky fault FSM. Optional q_ref toggle counter: JK_TRIO_CHECKER_TOGGLE_CNT_EN.
module jk_trio_checker
  import jk_trio_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int WARMUP       = 2,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             j,
  input  logic             k,
  input  logic             q_sr,
  input  logic             q_d,
  input  logic             q_t,
  output logic             q_ref,
  output logic [2:0]       mismatch,
  output logic             err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] mis_cnt_sr,
  output logic [CNT_W-1:0] mis_cnt_d,
  output logic [CNT_W-1:0] mis_cnt_t,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [2:0]       first_lane,
  output logic [CNT_W-1:0] first_cyc,
  output logic [CNT_W-1:0] tog_cnt
);

  localparam int WARM_W = (WARMUP < 2) ? 1 : $clog2(WARMUP + 1);
  localparam logic [WARM_W:0] WARM_LAST = (WARM_W + 1)'(2);

  chk_state_t       st;
  logic [WARM_W-1:0] warm_cnt;
  logic [2:0]        q_lane;
  logic [2:0]        cmp;
  logic              eval;
  logic [CNT_W-1:0]  mis_cnt [3];

  assign q_lane[LANE_SR] = q_sr;
  assign q_lane[LANE_D]  = q_d;
  assign q_lane[LANE_T]  = q_t;
  assign cmp   = q_lane ^ {3{q_ref}};
  assign eval  = (st == ST_CHECK) || ((st == ST_FAULT) && !STOP_ON_FAIL);
  assign state = st;

  // The model tracks the hardware flops, so only reset touches it (clr does not).
  always_ff @(posedge clk) begin
    if (reset) begin
      q_ref <= 1'b0;
    end else begin
      q_ref <= jk_next(q_ref, j, k);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      st         <= ST_IDLE;
      warm_cnt   <= '0;
      err        <= 1'b0;
      mismatch   <= '0;
      first_lane <= '0;
      first_cyc  <= '0;
    end else begin
      mismatch <= eval ? cmp : 3'b000;
      case (st)
        ST_IDLE: begin
          if (en) begin
            if (WARMUP == 0) begin
              st <= ST_CHECK;
            end else begin
              st       <= ST_WARM;
              warm_cnt <= WARM_W'(WARMUP);
            end
          end
        end
        ST_WARM: begin
          // Leave once the decremented count would reach 1.
          if (!en) begin
            st <= ST_IDLE;
          end else begin
            warm_cnt <= warm_cnt - WARM_W'(1);
            if ({1'b0, warm_cnt} <= WARM_LAST) begin
              st <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (|cmp) begin
            st         <= ST_FAULT;
            err        <= 1'b1;
            first_lane <= cmp;
            first_cyc  <= chk_cnt;
          end else if (!en) begin
            st <= ST_IDLE;
          end
        end
        default: begin
          st  <= ST_FAULT;
          err <= 1'b1;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane_cnt
      jk_sat_counter #(.W(CNT_W)) u_mis_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .inc   (eval && cmp[gi]),
        .count (mis_cnt[gi])
      );
    end
  endgenerate

  assign mis_cnt_sr = mis_cnt[LANE_SR];
  assign mis_cnt_d  = mis_cnt[LANE_D];
  assign mis_cnt_t  = mis_cnt[LANE_T];

  jk_sat_counter #(.W(CNT_W)) u_chk_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (eval),
    .count (chk_cnt)
  );

`ifdef JK_TRIO_CHECKER_TOGGLE_CNT_EN
  jk_sat_counter #(.W(CNT_W)) u_tog_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (jk_next(q_ref, j, k) != q_ref),
    .count (tog_cnt)
  );
`else
  assign tog_cnt = '0;
`endif

endmodule

// File: tb/tb_jk_trio_checker.sv
// Directed bench for jk_trio_checker: a behavioural trio stand-in drives the lanes,
// with lane forcing/stuck faults; a CNT_W=4 instance covers saturation.
module tb_jk_trio_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, en, clr, j, k, force_d;
  logic reset_b, en_b;
  logic qm, qm_b;

  logic        q_ref, err;
  logic [2:0]  mismatch, first_lane;
  logic [1:0]  state;
  logic [15:0] mis_cnt_sr, mis_cnt_d, mis_cnt_t, chk_cnt, first_cyc, tog_cnt;

  logic        q_ref_b, err_b;
  logic [2:0]  mismatch_b, first_lane_b;
  logic [1:0]  state_b;
  logic [3:0]  mis_cnt_sr_b, mis_cnt_d_b, mis_cnt_t_b, chk_cnt_b, first_cyc_b, tog_cnt_b;

  int total = 0;
  int bad   = 0;

  // Behavioural stand-in for the trio unit: one JK flop per instance.
  always @(posedge clk) begin
    if (reset) qm <= 1'b0;
    else if (j && k) qm <= ~qm;
    else if (j) qm <= 1'b1;
    else if (k) qm <= 1'b0;
  end

  always @(posedge clk) begin
    if (reset_b) qm_b <= 1'b0;
    else if (j && k) qm_b <= ~qm_b;
    else if (j) qm_b <= 1'b1;
    else if (k) qm_b <= 1'b0;
  end

  jk_trio_checker #(.CNT_W(16), .WARMUP(2), .STOP_ON_FAIL(1'b0)) u_dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .j(j), .k(k),
    .q_sr(qm), .q_d(force_d ? ~qm : qm), .q_t(qm),
    .q_ref(q_ref), .mismatch(mismatch), .err(err), .state(state),
    .mis_cnt_sr(mis_cnt_sr), .mis_cnt_d(mis_cnt_d), .mis_cnt_t(mis_cnt_t),
    .chk_cnt(chk_cnt), .first_lane(first_lane), .first_cyc(first_cyc), .tog_cnt(tog_cnt)
  );

  jk_trio_checker #(.CNT_W(4), .WARMUP(2), .STOP_ON_FAIL(1'b0)) u_dut_b (
    .clk(clk), .reset(reset_b), .en(en_b), .clr(1'b0), .j(j), .k(k),
    .q_sr(qm_b), .q_d(qm_b), .q_t(1'b0),
    .q_ref(q_ref_b), .mismatch(mismatch_b), .err(err_b), .state(state_b),
    .mis_cnt_sr(mis_cnt_sr_b), .mis_cnt_d(mis_cnt_d_b), .mis_cnt_t(mis_cnt_t_b),
    .chk_cnt(chk_cnt_b), .first_lane(first_lane_b), .first_cyc(first_cyc_b), .tog_cnt(tog_cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; clr = 1'b0; j = 1'b0; k = 1'b0; force_d = 1'b0;
    reset_b = 1'b1; en_b = 1'b0;

    // Reset state
    step(); step();
    check("rst_state", 32'(state), 32'd0);
    check("rst_q_ref", 32'(q_ref), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_mismatch", 32'(mismatch), 32'd0);
    check("rst_chk_cnt", 32'(chk_cnt), 32'd0);
    check("rst_first_cyc", 32'(first_cyc), 32'd0);

    // Clean random run: WARM after edge 1, CHECK after edge 2, 98 evaluated edges
    reset = 1'b0; en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      {j, k} = 2'($urandom_range(0, 3));
      step();
      if (i == 0) check("warm_entry", 32'(state), 32'd1);
      if (i == 1) check("check_entry", 32'(state), 32'd2);
    end
    check("run_state", 32'(state), 32'd2);
    check("run_err", 32'(err), 32'd0);
    check("run_q_ref", 32'(q_ref), 32'(qm));
    check("run_mis_sr", 32'(mis_cnt_sr), 32'd0);
    check("run_mis_d", 32'(mis_cnt_d), 32'd0);
    check("run_mis_t", 32'(mis_cnt_t), 32'd0);
    check("run_chk_cnt", 32'(chk_cnt), 32'd98);

    // Clear, re-arm, inject a D-lane divergence at chk_cnt = 10
    clr = 1'b1; step(); clr = 1'b0;
    check("clr_state", 32'(state), 32'd0);
    check("clr_chk_cnt", 32'(chk_cnt), 32'd0);
    for (int i = 0; i < 12; i++) begin
      {j, k} = 2'($urandom_range(0, 3));
      step();
    end
    check("pre_fault_chk", 32'(chk_cnt), 32'd10);
    force_d = 1'b1; step(); force_d = 1'b0;
    check("fault_mismatch", 32'(mismatch), 32'b010);
    check("fault_state", 32'(state), 32'd3);
    check("fault_err", 32'(err), 32'd1);
    check("fault_first_lane", 32'(first_lane), 32'b010);
    check("fault_first_cyc", 32'(first_cyc), 32'd10);
    check("fault_mis_d", 32'(mis_cnt_d), 32'd1);
    check("fault_chk_cnt", 32'(chk_cnt), 32'd11);

    // FAULT is sticky with en low; counting continues (STOP_ON_FAIL = 0)
    en = 1'b0; step();
    check("sticky_state", 32'(state), 32'd3);
    check("sticky_mismatch", 32'(mismatch), 32'd0);
    check("sticky_chk_cnt", 32'(chk_cnt), 32'd12);
    check("sticky_first_cyc", 32'(first_cyc), 32'd10);

    // clr together with a forced mismatch: clr wins
    clr = 1'b1; force_d = 1'b1; en = 1'b1; step(); clr = 1'b0; force_d = 1'b0;
    check("clrwin_state", 32'(state), 32'd0);
    check("clrwin_err", 32'(err), 32'd0);
    check("clrwin_mismatch", 32'(mismatch), 32'd0);
    check("clrwin_mis_d", 32'(mis_cnt_d), 32'd0);
    check("clrwin_chk_cnt", 32'(chk_cnt), 32'd0);
    check("clrwin_first_lane", 32'(first_lane), 32'd0);
    check("clrwin_first_cyc", 32'(first_cyc), 32'd0);

    // Force q_ref to 0 under clr, then 8 toggles
    en = 1'b0; j = 1'b0; k = 1'b1; clr = 1'b1; step(); clr = 1'b0;
    check("tog_start_q_ref", 32'(q_ref), 32'd0);
    check("tog_start_cnt", 32'(tog_cnt), 32'd0);
    en = 1'b1; j = 1'b1; k = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("tog_q_ref_%0d", i), 32'(q_ref), (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("tog_mismatch_%0d", i), 32'(mismatch), 32'd0);
    end
    check("tog_err", 32'(err), 32'd0);
    check("tog_state", 32'(state), 32'd2);
`ifdef JK_TRIO_CHECKER_TOGGLE_CNT_EN
    check("tog_cnt", 32'(tog_cnt), 32'd8);
`else
    check("tog_cnt", 32'(tog_cnt), 32'd0);
`endif

    // Reset mid-CHECK with q_ref = 1
    step();
    check("mid_q_ref", 32'(q_ref), 32'd1);
    check("mid_state", 32'(state), 32'd2);
    reset = 1'b1; step(); reset = 1'b0;
    check("mrst_q_ref", 32'(q_ref), 32'd0);
    check("mrst_state", 32'(state), 32'd0);
    check("mrst_err", 32'(err), 32'd0);
    check("mrst_mismatch", 32'(mismatch), 32'd0);
    check("mrst_chk_cnt", 32'(chk_cnt), 32'd0);
    check("mrst_tog_cnt", 32'(tog_cnt), 32'd0);
    j = 1'b0; k = 1'b0; step();
    check("post_rst_mismatch", 32'(mismatch), 32'd0);
    check("post_rst_state", 32'(state), 32'd1);

    // CNT_W = 4 instance: q_t stuck at 0 under toggling -> saturation at 15
    j = 1'b1; k = 1'b1; step(); step();
    reset_b = 1'b0; en_b = 1'b1;
    for (int i = 0; i < 40; i++) step();
    check("sat_mis_t", 32'(mis_cnt_t_b), 32'd15);
    check("sat_chk_cnt", 32'(chk_cnt_b), 32'd15);
    check("sat_mis_sr", 32'(mis_cnt_sr_b), 32'd0);
    check("sat_state", 32'(state_b), 32'd3);
    check("sat_first_lane", 32'(first_lane_b), 32'b100);
    check("sat_first_cyc", 32'(first_cyc_b), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jk_trio_checker.md
Name: jk_trio_checker

Overview:
Downstream consumer of the three-way JK flip-flop unit, which implements JK behaviour with an SR-, D- and T-based flop in parallel. It shares that unit's J/K drive, clock and reset, and runs a golden JK reference model in lockstep with it. It compares each lane's Q against the model every cycle and keeps per-lane mismatch counts, a sticky error and a first-failure record. It is used in-system as a self-check and as the bench scoreboard core.

Parameters:
CNT_W, 16, width of mismatch and checked-cycle counters (saturating).
WARMUP, 2, cycles spent in WARM after en rises before checking starts (0 = go straight to CHECK).
STOP_ON_FAIL, 0, when 1, counting freezes on entry to FAULT.

Ports:
clk  in  1  clock; rising edge used, shared with the trio unit.
reset  in  1  synchronous, active-high; asserted on the same edge as the trio unit's reset.
en  in  1  check enable.
clr  in  1  synchronous clear of counters, error state and first-fail record.
j  in  1  J, same net that drives the trio unit.
k  in  1  K, same net that drives the trio unit.
q_sr  in  1  SR-lane Q.
q_d  in  1  D-lane Q.
q_t  in  1  T-lane Q.
q_ref  out  1  golden JK model state.
mismatch  out  3  registered per-lane mismatch flags {t,d,sr}.
err  out  1  sticky error (state == FAULT).
state  out  2  FSM state: IDLE=0, WARM=1, CHECK=2, FAULT=3.
mis_cnt_sr  out  CNT_W  SR-lane mismatch count.
mis_cnt_d  out  CNT_W  D-lane mismatch count.
mis_cnt_t  out  CNT_W  T-lane mismatch count.
chk_cnt  out  CNT_W  number of cycles evaluated.
first_lane  out  3  mismatch vector latched at the first failure.
first_cyc  out  CNT_W  chk_cnt value at the first failure.
tog_cnt  out  CNT_W  q_ref toggle count (see Optional Feature).

Behaviour:
- Reset: all outputs and registers go to 0; state = IDLE. reset has priority over clr and all other inputs.
- Reference model (q_ref):
  - Updates every edge, independent of state and en.
  - JK = 00 hold, 01 → 0, 10 → 1, 11 → toggle.
  - q_ref and the trio flops update on the same edge from the same j/k, so all four agree after each edge.
- Compare:
  - cmp[i] = (q_lane[i] != q_ref).
  - On an edge where state is CHECK or FAULT (FAULT only when STOP_ON_FAIL = 0), mismatch <= cmp.
  - Otherwise mismatch <= 0.
  - Latency: a divergence appearing after edge n is visible on mismatch after edge n+1.
- Counters:
  - On each evaluated edge, chk_cnt increments.
  - Each mis_cnt_x increments when its cmp bit is 1.
  - All counters saturate at all-ones and never wrap.
  - Counters hold in IDLE and WARM.
- FSM (transitions on a clock edge; clr has priority over every arc except reset):
  - IDLE: en = 1 → WARM, loading warm counter with WARMUP; if WARMUP = 0, go directly to CHECK.
  - WARM: warm counter decrements each edge; at 1 → CHECK. en = 0 → IDLE.
  - CHECK: any cmp bit = 1 → FAULT. On that edge, first_lane <= cmp and first_cyc <= chk_cnt (pre-increment value). en = 0 → IDLE.
  - FAULT: sticky. en is ignored. Only clr or reset leave FAULT.
- clr:
  - Zeroes mismatch, all counters, first_lane and first_cyc; state → IDLE.
  - q_ref is not affected, since it mirrors the hardware state.
  - clr and a mismatch on the same edge: clr wins and nothing is recorded.
- first_lane and first_cyc are written only on the CHECK → FAULT edge.
- Reset mid-operation: the trio unit and the checker clear together, so q_ref = 0 matches all lanes with no false error.
- en toggling during WARM restarts the warm-up from IDLE.

Optional Feature:
Macro JK_TRIO_CHECKER_TOGGLE_CNT_EN.
- Defined: tog_cnt counts edges where q_ref changes value, in every state. Saturating at CNT_W; cleared by reset or clr.
- Undefined: no toggle logic is built and tog_cnt is tied to 0.

Decomposition:
- Package jk_trio_pkg:
  - state encoding constants ST_IDLE, ST_WARM, ST_CHECK, ST_FAULT.
  - lane index constants LANE_SR = 0, LANE_D = 1, LANE_T = 2.
  - JK opcode constants JK_HOLD, JK_RST, JK_SET, JK_TOG.
- One sub-module: jk_sat_counter (width parameter; inc, clr, synchronous reset). Instantiated for the three mismatch counters, chk_cnt and tog_cnt.

Test Plan:
1. reset high 2 cycles, then en = 1, WARMUP = 2, j/k random 100 cycles with the trio connected → state reaches CHECK after 2 cycles; err = 0; all mis_cnt = 0; chk_cnt = 98.
2. In CHECK, force q_d = ~q_ref for one cycle at chk_cnt = 10 → mismatch = 3'b010 one cycle later; state = FAULT; first_lane = 3'b010; first_cyc = 10; mis_cnt_d = 1.
3. j = k = 1 for 8 cycles from q_ref = 0 → q_ref alternates 1,0,…; no mismatch; with macro defined, tog_cnt = 8.
4. CNT_W = 4, STOP_ON_FAIL = 0, q_t stuck at 0 with j = k = 1 for 40 cycles → mis_cnt_t saturates at 15; chk_cnt = 15.
5. FAULT, then clr and a forced mismatch on the same edge → state = IDLE; counters = 0; first_lane = 0; err = 0.
6. Assert reset mid-CHECK with q_ref = 1 → next cycle q_ref = 0, state = IDLE, all outputs 0, no mismatch recorded.
